fir_coef_loader: RTL
====================

Name: fir_coef_loader

Overview:
- Upstream stage of myfir. Receives the 9 FIR coefficients as a serial word stream and drives the parallel B0..B8 coefficient buses that data_maker drives in simulation today.
- Double-buffered: words fill a shadow bank. The bank commits to the active B outputs atomically, and only on a cycle when the filter is not accepting a sample.
- Flags protocol errors (stray words, stalled load) with a sticky error bit.

Parameters:
NB, 12, coefficient word width (matches B0..B8 width)
NTAPS, 9, number of coefficients (B0..B8)
TMO, 255, max consecutive idle cycles (CVIN=0) tolerated inside a load before abort

Ports:
clk  in  1  system clock, all logic on rising edge
RST_n  in  1  synchronous, active-high reset (asserted = 1)
LOAD  in  1  single-cycle start-of-load strobe
CIN  in  NB  serial coefficient word, two's complement
CVIN  in  1  CIN valid qualifier
DVIN  in  1  myfir sample-valid (VIN of myfir); commit blocked while 1
B0..B8  out  NB each  active coefficients to myfir
CRDY  out  1  active bank holds a committed set (high after first commit, until reset)
BUSY  out  1  load or commit in progress
ERR  out  1  sticky protocol error

Behaviour:
- Reset (RST_n=1 at a clock edge):
  - B0..B8=0, shadow=0, CRDY=0, BUSY=0, ERR=0.
  - idx=0, timer=0, state=IDLE.
  - Reset overrides everything, including a load or commit in progress. A partial shadow is lost.
- States: IDLE, LOAD, COMMIT. Registered outputs only; no combinational path from any input to any output.
- IDLE:
  - LOAD=1 -> LOAD next cycle; idx=0, timer=0, ERR cleared, BUSY=1 from next cycle.
  - CVIN=1 without LOAD -> word ignored, ERR=1.
  - LOAD=1 and CVIN=1 in the same IDLE cycle -> word ignored (not stored), no error.
- LOAD:
  - CVIN=1 -> shadow[idx]<=CIN, idx++, timer=0. First accepted word maps to B0, last to B8.
  - CVIN=0 -> timer++. When timer reaches TMO -> ERR=1, BUSY=0, IDLE. Shadow is discarded and active B outputs are unchanged.
  - LOAD=1 in LOAD -> restart: idx=0, timer=0. A CVIN in the same cycle is ignored.
  - Word accepted with idx=NTAPS-1 -> COMMIT next cycle. Extra CVIN during COMMIT -> ignored, ERR=1.
- COMMIT:
  - DVIN=0 -> all B_k<=shadow[k] on the same edge, CRDY=1, BUSY=0, IDLE.
  - DVIN=1 -> hold in COMMIT, no timeout.
  - LOAD=1 in COMMIT -> ignored. The commit completes first.
- Latency: 9th word accepted at edge t -> COMMIT during cycle t+1. If DVIN=0 in t+1, new B values and BUSY=0 are visible after edge t+2. Each stalled DVIN cycle adds 1.
- B outputs change only on a commit edge or a reset edge. They never show a partially loaded set.
- Widths:
  - CIN is stored unmodified; no arithmetic on coefficients.
  - idx is ceil(log2(NTAPS)) bits and never wraps past NTAPS-1.
  - timer is ceil(log2(TMO+1)) bits and saturates at TMO.

Decomposition:
- Package fir_pkg:
  - NB and NTAPS constants.
  - State enum (IDLE, LOAD, COMMIT).
  - Coefficient word type logic signed [NB-1:0] and array type coef_arr_t [NTAPS].
- One natural sub-module, coef_bank:
  - Holds the shadow array with indexed write, and the active array with a parallel commit strobe.
  - FSM, idx and timer stay in fir_coef_loader.

Test Plan:
- Reset then LOAD, 9 back-to-back words 1..9 with DVIN=0 -> B0=1..B8=9 two cycles after the 9th word; CRDY=1; BUSY high for exactly 10 cycles; ERR=0.
- Set A (1..9) committed, then load set B (-1..-9, i.e. 0xFFF..0xFF7) with DVIN=1 held 5 cycles after the 9th word -> B stays A through the stall; B0=0xFFF..B8=0xFF7 one cycle after DVIN drops.
- Load 4 words then CVIN=0 for TMO cycles -> ERR=1, BUSY=0, B unchanged (0 if never committed, CRDY=0). A following LOAD clears ERR.
- Load 5 words, pulse LOAD, then send 9 words 100..108 -> B0=100..B8=108; the first 5 words never appear.
- CVIN=1 in IDLE with CIN=0x123 -> ERR=1, B unchanged; then a 10th word sent during COMMIT -> ERR=1, commit still completes with the 9 correct words.
- RST_n=1 asserted after 6 words of a load (with a previous set committed) -> all B=0, CRDY=0, BUSY=0 the next cycle; a subsequent full load of 1..9 commits cleanly.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader.
//   NB     - coefficient word width
//   NTAPS  - number of coefficients (B0..B8)
//   TMO    - idle cycles tolerated inside a load before it is aborted
//   IDX_W / TMR_W - widths of the word index and the idle timer
//   coef_t / coef_arr_t - one coefficient and a full bank of them
//   state_t - loader FSM states
package fir_pkg;
  localparam int NB    = 12;
  localparam int NTAPS = 9;
  localparam int TMO   = 255;
  localparam int IDX_W = $clog2(NTAPS);
  localparam int TMR_W = $clog2(TMO + 1);

  typedef logic signed [NB-1:0] coef_t;
  typedef coef_t coef_arr_t [NTAPS];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/fir_coef_loader_coef_bank.sv
// coef_bank: double-buffered coefficient storage.
//   clk, rst  - clock, synchronous active-high reset (clears both banks)
//   wr_en     - write wr_data into shadow[wr_idx]
//   wr_idx    - shadow slot to write
//   wr_data   - coefficient word, stored unmodified
//   commit    - copy the whole shadow bank into the active bank on this edge
//   active    - committed coefficients seen by the filter
module coef_bank
  import fir_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  coef_t            wr_data,
  input  logic             commit,
  output coef_arr_t        active
);

  coef_arr_t shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (wr_en) shadow[wr_idx] <= wr_data;
      // All taps move together so the filter never sees a mixed set.
      if (commit) active <= shadow;
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: turns a serial coefficient stream into the parallel
// B0..B8 buses of myfir.
//   clk        - system clock, rising edge
//   RST_n      - synchronous reset, active high
//   LOAD       - single-cycle start-of-load strobe (restarts a load in progress)
//   CIN, CVIN  - serial coefficient word and its valid qualifier
//   DVIN       - filter is taking a sample; a pending commit waits while high
//   B0..B8     - active coefficients
//   CRDY       - a committed set is present
//   BUSY       - load or commit in progress
//   ERR        - sticky protocol error, cleared by the next accepted LOAD
//   dbg_state  - current FSM state
// Stream handshake: a word is taken on every rising edge where CVIN=1 while
// loading and LOAD=0; there is no back-pressure, a word offered outside a
// load is dropped and flagged on ERR.
module fir_coef_loader
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          RST_n,
  input  logic          LOAD,
  input  logic [NB-1:0] CIN,
  input  logic          CVIN,
  input  logic          DVIN,
  output logic [NB-1:0] B0,
  output logic [NB-1:0] B1,
  output logic [NB-1:0] B2,
  output logic [NB-1:0] B3,
  output logic [NB-1:0] B4,
  output logic [NB-1:0] B5,
  output logic [NB-1:0] B6,
  output logic [NB-1:0] B7,
  output logic [NB-1:0] B8,
  output logic          CRDY,
  output logic          BUSY,
  output logic          ERR,
  output logic [1:0]    dbg_state
);

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [TMR_W-1:0]   timer_q, timer_n;
  logic               crdy_q, crdy_n;
  logic               err_q, err_n;
  logic               wr_en;
  logic               commit;
  coef_arr_t          active;

  always_ff @(posedge clk) begin
    if (RST_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      crdy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      timer_q <= timer_n;
      crdy_q  <= crdy_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    timer_n = timer_q;
    crdy_n  = crdy_q;
    err_n   = err_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          // A word arriving with the strobe belongs to no load: dropped silently.
          state_n = ST_LOAD;
          idx_n   = '0;
          timer_n = '0;
          err_n   = 1'b0;
        end else if (CVIN) begin
          err_n = 1'b1;
        end
      end
      ST_LOAD: begin
        if (LOAD) begin
          idx_n   = '0;
          timer_n = '0;
        end else if (CVIN) begin
          wr_en   = 1'b1;
          timer_n = '0;
          if (idx_q == IDX_W'(NTAPS - 1)) begin
            state_n = ST_COMMIT;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end else if (timer_q >= TMR_W'(TMO - 1)) begin
          // This idle cycle is the TMO-th in a row: abandon the load.
          // The shadow is left stale; the next load rewrites every slot.
          state_n = ST_IDLE;
          timer_n = '0;
          idx_n   = '0;
          err_n   = 1'b1;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (CVIN) err_n = 1'b1;
        if (!DVIN) begin
          commit  = 1'b1;
          crdy_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  coef_bank u_bank (
    .clk     (clk),
    .rst     (RST_n),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (CIN),
    .commit  (commit),
    .active  (active)
  );

  assign B0        = active[0];
  assign B1        = active[1];
  assign B2        = active[2];
  assign B3        = active[3];
  assign B4        = active[4];
  assign B5        = active[5];
  assign B6        = active[6];
  assign B7        = active[7];
  assign B8        = active[8];
  assign CRDY      = crdy_q;
  assign ERR       = err_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
